// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - operation encodings, FSM state type and signedness classes for mul_seq_unit
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mul_state_e;

  typedef enum logic [1:0] {
    CLS_SS,
    CLS_SU,
    CLS_UU
  } sign_class_e;

  function automatic sign_class_e op_class(input logic [1:0] op);
    case (op)
      OP_MULHSU: return CLS_SU;
      OP_MULHU:  return CLS_UU;
      default:   return CLS_SS;
    endcase
  endfunction

endpackage

// File: rtl/mul_operand_conv.sv
// rtl/mul_operand_conv.sv - combinational operand magnitude and result-sign extraction
module mul_operand_conv
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg
);

  logic rs1_signed;
  logic rs2_signed;
  logic rs1_neg;
  logic rs2_neg;

  always_comb begin
    rs1_signed = (op != OP_MULHU);
    rs2_signed = (op == OP_MUL) || (op == OP_MULH);
    rs1_neg    = rs1_signed & rs1[XLEN-1];
    rs2_neg    = rs2_signed & rs2[XLEN-1];
    // -MIN_INT wraps to itself, which is the correct unsigned magnitude
    mag1       = rs1_neg ? -rs1 : rs1;
    mag2       = rs2_neg ? -rs2 : rs2;
    neg        = rs1_neg ^ rs2_neg;
  end

endmodule

// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - sequential shift-add multiplier; optional last-result cache via MUL_RESULT_CACHE_EN
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      operation_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] product_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
      (XLEN % BITS_PER_CYCLE != 0)) begin : g_bad_param
    $fatal(1, "mul_seq_unit: illegal BITS_PER_CYCLE for XLEN");
  end

  mul_state_e state_q;
  mul_state_e state_d;

  logic [1:0]        op_q;
  logic              sign_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   product_q;

  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              res_neg;
  logic [2*XLEN-1:0] addend;
  logic [2*XLEN-1:0] fixed;
  logic              cache_hit;

  function automatic logic [XLEN-1:0] pick_half(input logic [1:0] op,
                                                input logic [2*XLEN-1:0] full);
    return (op == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
  endfunction

  mul_operand_conv #(.XLEN(XLEN)) u_conv (
    .op   (operation_i),
    .rs1  (rs1_i),
    .rs2  (rs2_i),
    .mag1 (mag1),
    .mag2 (mag2),
    .neg  (res_neg)
  );

  // The multiplicand register is pre-shifted each step, so the partial product lands in place
  always_comb begin
    addend = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_q[b]) addend = addend + (mcand_q << b);
    end
    fixed = sign_q ? -acc_q : acc_q;
  end

`ifdef MUL_RESULT_CACHE_EN
  logic              c_valid_q;
  logic [XLEN-1:0]   c_rs1_q;
  logic [XLEN-1:0]   c_rs2_q;
  sign_class_e       c_class_q;
  logic [2*XLEN-1:0] c_prod_q;
  logic [XLEN-1:0]   req_rs1_q;
  logic [XLEN-1:0]   req_rs2_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_class_q <= CLS_SS;
      c_prod_q  <= '0;
      req_rs1_q <= '0;
      req_rs2_q <= '0;
    end else if (kill_i) begin
      c_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        req_rs1_q <= rs1_i;
        req_rs2_q <= rs2_i;
      end
      if (state_q == ST_FIX) begin
        c_valid_q <= 1'b1;
        c_rs1_q   <= req_rs1_q;
        c_rs2_q   <= req_rs2_q;
        c_class_q <= op_class(op_q);
        c_prod_q  <= fixed;
      end
    end
  end

  // Low half of a product is signedness-independent, so MUL can reuse any class
  assign cache_hit = c_valid_q && (rs1_i == c_rs1_q) && (rs2_i == c_rs2_q) &&
                     ((operation_i == OP_MUL) || (op_class(operation_i) == c_class_q));
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    ready_o = (state_q == ST_IDLE);
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = cache_hit ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: begin
          valid_o = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      op_q      <= OP_MUL;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (!kill_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q     <= operation_i;
            sign_q   <= res_neg;
            mcand_q  <= {{XLEN{1'b0}}, mag1};
            mplier_q <= mag2;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(STEPS);
`ifdef MUL_RESULT_CACHE_EN
            if (cache_hit) product_q <= pick_half(operation_i, c_prod_q);
`endif
          end
        end
        ST_CALC: begin
          acc_q    <= acc_q + addend;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          acc_q     <= fixed;
          product_q <= pick_half(op_q, fixed);
        end
        default: ;
      endcase
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb/tb_mul_seq_unit.sv - scoreboard bench for mul_seq_unit with arithmetic reference model
module tb_mul_seq_unit;

  localparam logic [1:0] T_MUL    = 2'b00;
  localparam logic [1:0] T_MULH   = 2'b01;
  localparam logic [1:0] T_MULHSU = 2'b10;
  localparam logic [1:0] T_MULHU  = 2'b11;
  localparam int FULL_LAT = 32 / 2 + 2;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [1:0]  operation_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] product_o;

  mul_seq_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .start_i     (start_i),
    .kill_i      (kill_i),
    .operation_i (operation_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .product_o   (product_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  bit          c_valid = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_b = '0;
  int          c_cls = 0;

  function automatic logic [31:0] ref_prod(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] p;
    sa  = (op == T_MULHU) ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
    sbv = (op == T_MUL || op == T_MULH) ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    p   = sa * sbv;
    return (op == T_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int cls_of(input logic [1:0] op);
    return (op == T_MULHSU) ? 1 : (op == T_MULHU) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (ready_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready: got timeout expected ready_o=1 (cyc %0d)", cyc);
    end
  endtask

  task automatic start_raw(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int t);
    wait_ready();
    operation_i = op;
    rs1_i = a;
    rs2_i = b;
    start_i = 1'b1;
    t = cyc;
    @(posedge CLK); #1;
    start_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int   t;
    bit   hit;
    exp_t e;
    wait_ready();
    hit = 1'b0;
`ifdef MUL_RESULT_CACHE_EN
    hit = c_valid && (a == c_a) && (b == c_b) && (op == T_MUL || cls_of(op) == c_cls);
`endif
    if (!hit) begin
      c_valid = 1'b1;
      c_a = a;
      c_b = b;
      c_cls = cls_of(op);
    end
    operation_i = op;
    rs1_i = a;
    rs2_i = b;
    start_i = 1'b1;
    t = cyc;
    e.prod = exp;
    e.at = t + (hit ? 1 : FULL_LAT);
    sbq.push_back(e);
    @(posedge CLK); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || ready_o !== 1'b1) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (valid_o === 1'b1) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got product %h expected no valid_o (cyc %0d)",
                   product_o, cyc);
        end else begin
          e = sbq.pop_front();
          vectors++;
          if (product_o !== e.prod) begin
            miscompares++;
            $display("FAIL product: got %h expected %h (cyc %0d)", product_o, e.prod, cyc);
          end
          vectors++;
          if (cyc != e.at) begin
            miscompares++;
            $display("FAIL latency: got valid_o at cyc %0d expected %0d", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin : stim
    int          t;
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] specials [4];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h7FFF_FFFF;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready", {31'b0, ready_o}, 32'd1);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_product", product_o, 32'h0);
    rst = 1'b0;

    issue(T_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(T_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(T_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(T_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);

    // start pulse while busy must be dropped
    issue(T_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    repeat (4) begin @(posedge CLK); #1; end
    chk("busy_ready", {31'b0, ready_o}, 32'd0);
    operation_i = T_MUL;
    rs1_i = 32'd3;
    rs2_i = 32'd5;
    start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    wait_drain();

    prev = product_o;
    start_raw(T_MULHU, 32'h1357_9BDF, 32'h2468_ACE0, t);
    c_valid = 1'b0;
    while (cyc < t + 5) begin @(posedge CLK); #1; end
    kill_i = 1'b1;
    @(posedge CLK); #1;
    kill_i = 1'b0;
    chk("kill_ready", {31'b0, ready_o}, 32'd1);
    chk("kill_product_hold", product_o, prev);
    repeat (20) begin @(posedge CLK); #1; end
    chk("kill_product_late", product_o, prev);

    start_raw(T_MUL, 32'h0BAD_F00D, 32'h0000_1234, t);
    c_valid = 1'b0;
    while (cyc < t + 8) begin @(posedge CLK); #1; end
    rst = 1'b1;
    @(posedge CLK); #1;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_product", product_o, 32'h0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    rst = 1'b0;
    repeat (22) begin @(posedge CLK); #1; end

    issue(T_MUL,   32'h1234_5678, 32'h9ABC_DEF0, ref_prod(T_MUL, 32'h1234_5678, 32'h9ABC_DEF0));
    issue(T_MULH,  32'h1234_5678, 32'h9ABC_DEF0, 32'hF8CC_93D6);
    issue(T_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_prod(T_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

    a = '0;
    b = '0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
        b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      end
      issue(op, a, b, ref_prod(op, a, b));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    wait_drain();
    repeat (3) begin @(posedge CLK); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq_unit.md
MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4; XLEN % BITS_PER_CYCLE == 0.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request; accepted only when ready_o=1.
REQ-006 kill_i  input  1  pipeline flush; aborts any operation in flight.
REQ-007 operation_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 rs1_i  input  XLEN  multiplicand; rs2_i  input  XLEN  multiplier.
REQ-009 ready_o  output  1  unit idle, can accept start_i.
REQ-010 valid_o  output  1  one-cycle pulse, product_o valid.
REQ-011 product_o  output  XLEN  selected result half.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE; ready_o=1 only in IDLE.
REQ-013 IDLE: start_i=1 and kill_i=0 -> latch operation, operands converted to magnitudes plus result-sign bit, clear 2*XLEN accumulator, counter=XLEN/BITS_PER_CYCLE, go CALC.
REQ-014 Signedness: MUL and MULH signed x signed; MULHSU rs1 signed x rs2 unsigned; MULHU unsigned x unsigned.
REQ-015 CALC: each cycle add (multiplicand x low BITS_PER_CYCLE multiplier bits), shifted to position, into accumulator; shift multiplier; decrement counter; counter reaching 0 -> FIX.
REQ-016 FIX: two's-complement negate full 2*XLEN accumulator when result-sign=1; go DONE.
REQ-017 DONE: valid_o=1 for exactly one cycle; next state IDLE.
REQ-018 product_o SHALL equal bits [XLEN-1:0] for MUL, [2*XLEN-1:XLEN] otherwise; held stable from DONE until next accepted start.
REQ-019 Latency: start accepted cycle T -> valid_o at T+XLEN/BITS_PER_CYCLE+2 (T+18 for defaults).
REQ-020 start_i while ready_o=0 SHALL be ignored, no queueing.
REQ-021 kill_i=1 in any state SHALL force IDLE next cycle, suppress valid_o, leave product_o unchanged; kill_i with start_i in IDLE -> start ignored.
REQ-022 Overflow of 2*XLEN accumulator SHALL be impossible by construction; no truncation before FIX.

Reset
REQ-023 rst=1 SHALL, at the clock edge, force IDLE, valid_o=0, product_o=0, accumulator/counter=0; rst overrides start_i and kill_i.
REQ-024 rst asserted mid-CALC SHALL abort with no valid_o pulse.

Configuration
REQ-025 Macro MUL_RESULT_CACHE_EN SHALL compile in a last-result cache: stored rs1, rs2, signedness class, full 2*XLEN product, cache-valid bit.
REQ-026 With macro: start with equal rs1/rs2, cache valid, and (operation MUL, or same signedness class) SHALL bypass CALC/FIX: IDLE -> DONE, valid_o at T+1.
REQ-027 With macro: cache written on every FIX completion; cache-valid cleared by rst and kill_i.
REQ-028 Without macro: no cache storage; every operation takes REQ-019 latency.

Structure
REQ-029 Package mul_pkg SHALL hold the operation encoding constants and the state enumeration typedef.
REQ-030 Sub-module mul_operand_conv SHALL be combinational: operation plus operands -> magnitudes and result-sign bit.
REQ-031 Parameter legality SHALL be checked at elaboration; illegal BITS_PER_CYCLE is a fatal error.

Verification
REQ-032 MUL then MULH, rs1=rs2=0xFFFFFFFF -> product_o 0x00000001, then 0x00000000.
REQ-033 MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0x00000002 -> 0xFFFFFFFF.
REQ-034 MULH rs1=rs2=0x80000000 -> 0x40000000; valid_o exactly at T+18, start_i during busy ignored.
REQ-035 kill_i at T+5 of MULHU -> ready_o=1 at T+6, no valid_o, product_o retains prior value; rst at T+8 of MUL -> all outputs 0 next cycle.
REQ-036 MUL_RESULT_CACHE_EN: MUL 0x12345678 x 0x9ABCDEF0 then MULH same operands -> second valid_o at T+1, value 0xF8CC93D6; MULHU same operands -> full latency.
